sla_seq: RTL and testbench



---
 rtl/sla_seq_if.sv | 42 ++++
 rtl/sla_seq.sv | 117 +++++++++++
 tb/tb_sla_seq.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sla_seq_if.sv
// ---------------------------------------------------------------------------
// sla_seq_if
// Handshake/data bundle between the ALU issue stage and the multi-cycle
// arithmetic-left-shift sequencer.
//
// Signals:
//   start   - request a shift (upstream holds it until busy is low)
//   a       - operand to shift
//   amt     - shift count, 0..WIDTH-1
//   result  - shifted operand, valid with done and held afterwards
//   busy    - operation in progress
//   done    - one-cycle pulse when result becomes valid
//   ovf     - sticky signed-overflow flag of the last operation
//
// Modports:
//   master  - upstream side (drives start/a/amt)
//   slave   - sequencer side (drives result/busy/done/ovf)
// ---------------------------------------------------------------------------
interface sla_seq_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [CNT_W-1:0] amt;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (
        output start, a, amt,
        input  result, busy, done, ovf
    );

    modport slave (
        input  start, a, amt,
        output result, busy, done, ovf
    );

endinterface

// File: rtl/sla_seq.sv
// ---------------------------------------------------------------------------
// sla_seq
// Multi-cycle arithmetic-left-shift sequencer. Repeats the single-step
// shift-left operation once per clock until the requested amount has been
// applied, then presents the value for one done cycle and holds it until the
// next accepted start.
//
// Ports:
//   clk      - rising-edge clock
//   reset_n  - synchronous, active-low reset
//   bus      - sla_seq_if.slave (start/a/amt in, result/busy/done/ovf out)
//
// Parameters:
//   WIDTH    - data width (default 32)
//   CNT_W    - shift-count width, log2(WIDTH) (default 5)
//
// Optional feature:
//   SLA_SEQ_OVF_EN - when defined, a sticky signed-overflow flag is kept
//                    across the shift steps; otherwise ovf is tied to 0.
// ---------------------------------------------------------------------------
module sla_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    sla_seq_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SLA_SEQ_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // State and datapath registers. Reset clears everything so the result
    // bus reads zero and any operation in flight is abandoned without a done.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef SLA_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
`ifdef SLA_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next-state and datapath update. A start is accepted from both IDLE and
    // DONE, so a request held through the DONE cycle launches the next
    // operation with no idle gap. A zero count skips SHIFT entirely. In SHIFT
    // the count reaching one means this is the last step.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
`ifdef SLA_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    acc_d   = bus.a;
                    cnt_d   = bus.amt;
`ifdef SLA_SEQ_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = (bus.amt != '0) ? SHIFT : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                acc_d = {acc_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
`ifdef SLA_SEQ_OVF_EN
                // A step changes the sign exactly when the two top bits differ.
                ovf_d = ovf_q | (acc_q[WIDTH-1] ^ acc_q[WIDTH-2]);
`endif
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are pure decodes of the registered state, so they are glitch
    // free toward the ALU result mux.
    always_comb begin
        bus.busy   = (state_q == SHIFT);
        bus.done   = (state_q == DONE);
        bus.result = acc_q;
`ifdef SLA_SEQ_OVF_EN
        bus.ovf    = ovf_q;
`else
        bus.ovf    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_sla_seq.sv
// ---------------------------------------------------------------------------
// tb_sla_seq
// Self-checking bench for sla_seq. The reference model computes each
// operation's outcome directly: result is the operand shifted left by the
// count, overflow is whether an arithmetic shift left and back fails to
// reproduce the operand, and the handshake follows a fixed timeline of
// amt busy cycles followed by one done cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sla_seq;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    logic clk;
    logic reset_n;

    int nAsserts = 0;
    int nFails   = 0;

    logic [WIDTH-1:0] lastResult;

    sla_seq_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    sla_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so a broken design can never hang the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive the upstream side of the handshake.
    task automatic applyStimulus(input logic s, input logic [WIDTH-1:0] av,
                                 input logic [CNT_W-1:0] amtv);
        bus.start = s;
        bus.a     = av;
        bus.amt   = amtv;
    endtask

    // One comparison: counts it, reports and counts a failure.
    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs,
                               input logic [WIDTH-1:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("[TB] assertion %s", tag);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Reference overflow: a sign change happens on some step iff the value
    // cannot survive an arithmetic shift left followed by a shift right.
    function automatic logic modelOvf(input logic [WIDTH-1:0] av,
                                      input logic [CNT_W-1:0] amtv);
`ifdef SLA_SEQ_OVF_EN
        logic signed [WIDTH-1:0] sa, sh;
        sa = $signed(av);
        sh = sa <<< amtv;
        sh = sh >>> amtv;
        return sh != sa;
`else
        return 1'b0;
`endif
    endfunction

    // Issue one operation and follow the expected timeline up to and
    // including the done cycle. Ends sampled inside the done cycle so the
    // caller may present the next start for a back-to-back launch.
    // With disturb set, a competing start is pulsed during SHIFT.
    task automatic runOp(input string tag, input logic [WIDTH-1:0] av,
                         input logic [CNT_W-1:0] amtv, input bit disturb);
        logic [WIDTH-1:0] expResult;
        logic             expOvf;
        expResult = av << amtv;
        expOvf    = modelOvf(av, amtv);
        applyStimulus(1'b1, av, amtv);
        nextCycle();
        applyStimulus(1'b0, $urandom, CNT_W'($urandom));
        for (int j = 0; j <= int'(amtv); j++) begin
            checkOutput({tag, ".busy"}, {31'b0, bus.busy}, {31'b0, (j < int'(amtv))});
            checkOutput({tag, ".done"}, {31'b0, bus.done}, {31'b0, (j == int'(amtv))});
            if (j == int'(amtv)) begin
                checkOutput({tag, ".result"}, bus.result, expResult);
                checkOutput({tag, ".ovf"}, {31'b0, bus.ovf}, {31'b0, expOvf});
            end
            if (disturb && j == 1) applyStimulus(1'b1, 32'd7, 5'd2);
            if (disturb && j == 2) applyStimulus(1'b0, 32'd0, 5'd0);
            if (j < int'(amtv)) nextCycle();
        end
        lastResult = expResult;
    endtask

    // Idle cycles after an operation: nothing in progress, result held.
    task automatic idleCheck(input string tag, input int n);
        applyStimulus(1'b0, $urandom, CNT_W'($urandom));
        for (int k = 0; k < n; k++) begin
            nextCycle();
            checkOutput({tag, ".idleBusy"}, {31'b0, bus.busy}, 32'd0);
            checkOutput({tag, ".idleDone"}, {31'b0, bus.done}, 32'd0);
            checkOutput({tag, ".idleResult"}, bus.result, lastResult);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [CNT_W-1:0] ramt;

        // Reset held with an active start request: nothing may leak out.
        reset_n = 1'b0;
        applyStimulus(1'b1, 32'hFFFF_FFFF, 5'd5);
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            checkOutput("rst.result", bus.result, 32'd0);
            checkOutput("rst.busy", {31'b0, bus.busy}, 32'd0);
            checkOutput("rst.done", {31'b0, bus.done}, 32'd0);
            checkOutput("rst.ovf", {31'b0, bus.ovf}, 32'd0);
        end
        reset_n    = 1'b1;
        lastResult = '0;
        idleCheck("rstRelease", 2);

        // Basic shift.
        runOp("basic", 32'h0000_0003, 5'd4, 1'b0);
        checkOutput("basic.const", bus.result, 32'h0000_0030);
        idleCheck("basic", 1);

        // Zero count goes straight to DONE.
        runOp("zero", 32'hDEAD_BEEF, 5'd0, 1'b0);
        checkOutput("zero.const", bus.result, 32'hDEAD_BEEF);
        idleCheck("zero", 1);

        // Sign change on the single step.
        runOp("ovf", 32'h4000_0000, 5'd1, 1'b0);
        checkOutput("ovf.const", bus.result, 32'h8000_0000);
        idleCheck("ovf", 1);

        // Start during SHIFT is dropped; start in DONE launches immediately.
        runOp("busyIgnore", 32'h0000_0001, 5'd3, 1'b1);
        checkOutput("busyIgnore.const", bus.result, 32'h0000_0008);
        runOp("backToBack", 32'h0000_0007, 5'd2, 1'b0);
        checkOutput("backToBack.const", bus.result, 32'h0000_001C);
        idleCheck("backToBack", 1);

        // Reset in the 5th SHIFT cycle aborts without a done pulse.
        applyStimulus(1'b1, 32'h0000_0001, 5'd20);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 5'd0);
        for (int k = 0; k < 4; k++) nextCycle();
        checkOutput("midRst.preBusy", {31'b0, bus.busy}, 32'd1);
        reset_n = 1'b0;
        nextCycle();
        checkOutput("midRst.result", bus.result, 32'd0);
        checkOutput("midRst.busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("midRst.done", {31'b0, bus.done}, 32'd0);
        reset_n    = 1'b1;
        lastResult = '0;
        idleCheck("midRst", 22);
        runOp("afterRst", 32'h0000_0001, 5'd1, 1'b0);
        checkOutput("afterRst.const", bus.result, 32'h0000_0002);
        idleCheck("afterRst", 1);

        // Randomized operations with random gaps (a zero gap is back-to-back).
        for (int n = 0; n < 40; n++) begin
            ra   = $urandom;
            ramt = CNT_W'($urandom_range(0, WIDTH - 1));
            if (n % 4 == 0) ra = {ra[31], ra[31], ra[29:0]};
            runOp("rand", ra, ramt, 1'b0);
            idleCheck("rand", int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
